// File: rtl/stencil_shell_pkg.sv
// rtl/stencil_shell_pkg.sv - shared types and constants for the stencil stream shell
package stencil_shell_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_EOF
  } shell_state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH      = 512;
  localparam int DEF_RST_CYCLES = 4;
  localparam int DEF_CNT_W      = 16;

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - standard-read synchronous FIFO with flush
module stream_fifo
  import stencil_shell_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DATA_W-1:0] dout_q;
  logic              do_wr;
  logic              do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = dout_q;

  // A read in the same cycle frees a slot, so a write at full still lands.
  assign do_rd = rd_en && !empty && !srst;
  assign do_wr = wr_en && (!full || do_rd) && !srst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/stencil_stream_shell.sv
// rtl/stencil_stream_shell.sv - host/core stream shell: three FIFOs plus job sequencer
module stencil_stream_shell
  import stencil_shell_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              coeff_wren,
  input  logic [DATA_W-1:0] coeff_data,
  input  logic              coeff_open,
  output logic              coeff_full,
  input  logic              in_wren,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_open,
  output logic              in_full,
  input  logic              rd_rden,
  input  logic              rd_open,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_empty,
  output logic              rd_eof,
  input  logic              core_coeff_rd_en,
  output logic [DATA_W-1:0] core_coeff_data,
  output logic              core_coeff_empty,
  input  logic              core_in_rd_en,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_empty,
  input  logic              core_out_wr_en,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              core_out_full,
  input  logic              core_done,
  output logic              core_reset,
  output logic              busy,
  output logic [CNT_W-1:0]  job_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  shell_state_t     state_q;
  logic [RCW-1:0]   rst_cnt_q;
  logic             core_reset_q;
  logic             busy_q;
  logic             rd_eof_q;
  logic [CNT_W-1:0] job_cnt_q;
  logic [CNT_W-1:0] abort_cnt_q;
  logic             res_srst;

  assign res_srst   = !rd_open || (state_q == ST_RESET);
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign rd_eof     = rd_eof_q;
  assign job_cnt    = job_cnt_q;
  assign abort_cnt  = abort_cnt_q;

  stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_coeff_fifo (
    .clk(clk), .reset_n(reset_n), .srst(!coeff_open),
    .din(coeff_data), .wr_en(coeff_wren), .rd_en(core_coeff_rd_en),
    .dout(core_coeff_data), .full(coeff_full), .empty(core_coeff_empty)
  );

  stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .reset_n(reset_n), .srst(!in_open),
    .din(in_data), .wr_en(in_wren), .rd_en(core_in_rd_en),
    .dout(core_in_data), .full(in_full), .empty(core_in_empty)
  );

  stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .reset_n(reset_n), .srst(res_srst),
    .din(core_out_data), .wr_en(core_out_wr_en), .rd_en(rd_rden),
    .dout(rd_data), .full(core_out_full), .empty(rd_empty)
  );

  // Outputs are set together with the transition that causes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      rd_eof_q     <= 1'b0;
      job_cnt_q    <= '0;
      abort_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        ST_IDLE: begin
          if (in_open && rd_open) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (!rd_open) begin
            state_q      <= ST_RESET;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            abort_cnt_q  <= abort_cnt_q + CNT_W'(1);
          end else if (state_q == ST_RUN) begin
            if (core_done) begin
              state_q <= ST_DRAIN;
            end
          end else if (rd_empty && !core_out_wr_en) begin
            state_q  <= ST_EOF;
            busy_q   <= 1'b0;
            rd_eof_q <= 1'b1;
          end
        end
        ST_EOF: begin
          if (!rd_open) begin
            state_q      <= ST_RESET;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            rd_eof_q     <= 1'b0;
            job_cnt_q    <= job_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q      <= ST_RESET;
          rst_cnt_q    <= '0;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
          rd_eof_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
